// File: rtl/alu_nibble_seq.sv
// Drives one 4-bit 74181 slice nibble by nibble, LSB first, to build a 4*NIBBLES-bit result with carry-out, equality and zero flags.
// Optional abort input is enabled by defining ALU_NIBBLE_SEQ_ABORT_EN.
module alu_nibble_seq #(
    parameter int NIBBLES = 4,
    localparam int W = 4 * NIBBLES
) (
    input  logic         clk,
    input  logic         rst,
`ifdef ALU_NIBBLE_SEQ_ABORT_EN
    input  logic         abort,
`endif
    input  logic         start,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    input  logic [3:0]   sel,
    input  logic         mode,
    input  logic         cin_n,
    output logic         in_ready,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         cout_n,
    output logic         eq,
    output logic         zero,
    output logic [3:0]   alu_A,
    output logic [3:0]   alu_B,
    output logic [3:0]   alu_S,
    output logic         alu_M,
    output logic         alu_Cn,
    input  logic [3:0]   alu_F,
    input  logic         alu_Cn_out,
    input  logic         alu_A_eq_B
);

    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          r_state;
    logic [IW-1:0]   r_idx;
    logic [W-1:0]    r_op_a;
    logic [W-1:0]    r_op_b;
    logic [W-1:0]    r_res;
    logic [W-1:0]    r_result;
    logic [3:0]      r_sel;
    logic            r_mode;
    logic            r_carry;
    logic            r_eq_acc;
    logic            r_in_ready;
    logic            r_busy;
    logic            r_done;
    logic            r_cout_n;
    logic            r_eq;
    logic            r_zero;

    logic [W-1:0]    w_res_next;
    logic            w_last;
    logic            w_abort;

`ifdef ALU_NIBBLE_SEQ_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    assign w_last = (r_idx == IW'(NIBBLES - 1));

    // Staged result with the current slice output merged into its nibble.
    always_comb begin
        w_res_next = r_res;
        w_res_next[{r_idx, 2'b00} +: 4] = alu_F;
    end

    // Slice operand mux; data inputs are parked at zero and carry at "none" outside RUN.
    always_comb begin
        if (r_state == ST_RUN) begin
            alu_A  = r_op_a[{r_idx, 2'b00} +: 4];
            alu_B  = r_op_b[{r_idx, 2'b00} +: 4];
            alu_Cn = r_carry;
        end else begin
            alu_A  = 4'h0;
            alu_B  = 4'h0;
            alu_Cn = 1'b1;
        end
    end

    assign alu_S    = r_sel;
    assign alu_M    = r_mode;
    assign in_ready = r_in_ready;
    assign busy     = r_busy;
    assign done     = r_done;
    assign result   = r_result;
    assign cout_n   = r_cout_n;
    assign eq       = r_eq;
    assign zero     = r_zero;

    // Sequencer FSM: latch on start, one nibble per cycle, publish flags on the last nibble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_idx      <= {IW{1'b0}};
            r_op_a     <= {W{1'b0}};
            r_op_b     <= {W{1'b0}};
            r_res      <= {W{1'b0}};
            r_result   <= {W{1'b0}};
            r_sel      <= 4'h0;
            r_mode     <= 1'b0;
            r_carry    <= 1'b1;
            r_eq_acc   <= 1'b1;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_cout_n   <= 1'b1;
            r_eq       <= 1'b0;
            r_zero     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_op_a     <= op_a;
                        r_op_b     <= op_b;
                        r_sel      <= sel;
                        r_mode     <= mode;
                        r_carry    <= cin_n;
                        r_idx      <= {IW{1'b0}};
                        r_eq_acc   <= 1'b1;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= ST_RUN;
                    end else begin
                        r_in_ready <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (w_abort) begin
                        r_idx      <= {IW{1'b0}};
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b0;
                        r_state    <= ST_IDLE;
                    end else begin
                        r_res    <= w_res_next;
                        r_carry  <= alu_Cn_out;
                        r_eq_acc <= r_eq_acc & alu_A_eq_B;
                        if (w_last) begin
                            r_result <= w_res_next;
                            r_cout_n <= alu_Cn_out;
                            r_eq     <= r_eq_acc & alu_A_eq_B;
                            r_zero   <= (w_res_next == {W{1'b0}});
                            r_idx    <= {IW{1'b0}};
                            r_done   <= 1'b1;
                            r_busy   <= 1'b0;
                            r_state  <= ST_DONE;
                        end else begin
                            r_idx <= r_idx + IW'(1);
                        end
                    end
                end
                ST_DONE: begin
                    r_done     <= 1'b0;
                    r_in_ready <= 1'b1;
                    r_state    <= ST_IDLE;
                end
                default: begin
                    r_done     <= 1'b0;
                    r_busy     <= 1'b0;
                    r_in_ready <= 1'b1;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/alu_nibble_seq.md
Name: alu_nibble_seq

Overview:
- Multi-cycle sequencer that sits directly upstream of ALU_4bit_74181 and consumes its outputs.
- Performs a 4*NIBBLES-bit operation on one 4-bit 74181 slice, one nibble per clock, LSB first.
- Ripples the slice's carry between nibbles through a register.
- Assembles the wide result plus carry-out, equality and zero flags behind a start/done handshake.
- The ALU slice itself remains purely combinational and is instantiated alongside this block.

Parameters:
NIBBLES, 4, number of 4-bit slices processed; operand width W = 4*NIBBLES; legal range 1..8

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, asynchronous, active-high
start  input  1  request; accepted only when in_ready=1
op_a  input  W  operand A, latched on accepted start
op_b  input  W  operand B, latched on accepted start
sel  input  4  74181 function select S, latched on accepted start
mode  input  1  74181 M (1=logic, 0=arithmetic), latched on accepted start
cin_n  input  1  carry-in to nibble 0, 74181 polarity (1 = no carry), latched on accepted start
in_ready  output  1  high in IDLE only
busy  output  1  high in RUN
done  output  1  one-cycle pulse when result/flags are valid
result  output  W  assembled F, held until next accepted start
cout_n  output  1  final nibble's Cn_out, 74181 polarity
eq  output  1  AND of A_eq_B over all nibbles
zero  output  1  result == 0
alu_A  output  4  to ALU A
alu_B  output  4  to ALU B
alu_S  output  4  to ALU S
alu_M  output  1  to ALU M
alu_Cn  output  1  to ALU Cn
alu_F  input  4  from ALU F
alu_Cn_out  input  1  from ALU Cn_out
alu_A_eq_B  input  1  from ALU A_eq_B

Behaviour:
Reset and state machine:
- Reset values: FSM=IDLE; idx=0; result=0; done=0; busy=0; cout_n=1; eq=0; zero=0. alu_A, alu_B, alu_S and alu_M are 0; alu_Cn=1.
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. When start=1 at an edge:
  - latch op_a, op_b, sel, mode and cin_n;
  - set carry_reg=cin_n, idx=0 and eq_acc=1;
  - go to RUN.
- RUN: the block combinationally drives alu_A=op_a_r[4*idx+:4], alu_B=op_b_r[4*idx+:4], alu_S=sel_r, alu_M=mode_r and alu_Cn=carry_reg. At each edge it:
  - writes alu_F into res_r[4*idx+:4];
  - sets carry_reg to alu_Cn_out;
  - sets eq_acc to eq_acc & alu_A_eq_B;
  - increments idx.
- RUN exit: when idx=NIBBLES-1 is captured, the block copies res_r to result, alu_Cn_out to cout_n and the final eq_acc to eq, sets zero=(final result==0), and goes to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.

Timing and handshake:
- Latency: start sampled at edge k; done is high in the cycle after edge k+NIBBLES. Throughput is one operation per NIBBLES+2 cycles.
- start is ignored in RUN and DONE; no queuing.
- Outputs hold their values after done until the next capture completes. result must not change during RUN; stage it in res_r.
- Carry propagates in 74181 polarity unchanged: each nibble's Cn is the previous nibble's Cn_out. This applies in logic mode too; cout_n is still reported and is don't-care for logic ops.
- eq is meaningful only for sel=0110, mode=0, cin_n=1, but is always computed.
- Outside RUN: alu_A=alu_B=0, alu_S/alu_M hold the latched values, alu_Cn=1.
- Asynchronous reset mid-RUN: all outputs and state return to reset values immediately, with no done pulse.
- NIBBLES=1: RUN lasts one cycle.

Optional Feature:
ALU_NIBBLE_SEQ_ABORT_EN
- Defined: adds input port abort (1 bit).
  - abort=1 at an edge in RUN: go to IDLE, no done, and result/cout_n/eq/zero keep their previous values.
  - abort in IDLE or DONE has no effect.
  - abort has priority over the last-nibble capture.
- Undefined: no abort port; RUN always completes.

Test Plan:
1. NIBBLES=4, real 74181 attached; op_a=0x1234, op_b=0x0FFF, sel=1001, mode=0, cin_n=1 -> after 4 RUN cycles done=1, result=0x2233, cout_n=1, zero=0.
2. op_a=0xFFFF, op_b=0x0001, sel=1001, mode=0, cin_n=1 -> result=0x0000, cout_n=0, zero=1 (carry rippled through all 4 nibbles).
3. op_a=op_b=0x5A5A, sel=0110, mode=0, cin_n=1 -> result=0xFFFF, eq=1; repeat with op_b=0x5A5B -> eq=0.
4. Logic AND, sel=1011, mode=1, op_a=0xF0F0, op_b=0xCCCC -> result=0xC0C0; start pulsed during busy is ignored (exactly one done; in_ready low in RUN/DONE).
5. Assert rst during RUN at idx=2 -> busy=0, done never pulses, result=0, cout_n=1; next start then completes normally.
6. With ALU_NIBBLE_SEQ_ABORT_EN: run case 1, then start case 2 and abort at idx=1 -> no done, result stays 0x2233; next start completes.
